// File: rtl/banked_fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : banked_fifo_pkg                                            |
// | Description : Width helpers and pointer slicing for the banked FIFO.     |
// |               A pointer is laid out as {wrap, row, bank}, with the bank  |
// |               select in the least significant bits. This interleaves     |
// |               consecutive entries across the banks.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package banked_fifo_pkg;

  // Ceiling log2, evaluated at elaboration time.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Bank select width.
  function automatic int unsigned bank_w(input int unsigned num_banks);
    return clog2(num_banks);
  endfunction

  // Row address width.
  function automatic int unsigned row_w(input int unsigned bank_depth);
    return clog2(bank_depth);
  endfunction

  // Pointer width, including the wrap bit.
  function automatic int unsigned ptr_w(input int unsigned num_banks, input int unsigned bank_depth);
    return clog2(num_banks * bank_depth) + 1;
  endfunction

  // Occupancy counter width. It must hold the value DEPTH itself.
  function automatic int unsigned cnt_w(input int unsigned num_banks, input int unsigned bank_depth);
    return clog2(num_banks * bank_depth) + 1;
  endfunction

  // Returns the bank field of a pointer.
  function automatic int unsigned bank_of(input logic [31:0] ptr, input int unsigned bw);
    return ptr & ((32'd1 << bw) - 32'd1);
  endfunction

  // Returns the row field of a pointer.
  function automatic int unsigned row_of(input logic [31:0] ptr, input int unsigned bw,
                                         input int unsigned raw);
    return (ptr >> bw) & ((32'd1 << raw) - 32'd1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/banked_fifo_ptr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : banked_fifo_ptr                                            |
// | Description : Pointer, occupancy and error-flag keeper for the banked    |
// |               FIFO. It decides which read and write fire each cycle.     |
// |               Reads win a bank conflict.                                 |
// | Ports       : clk, rst (async, active low), en, flush, we, re            |
// |               -> rd_fire, wr_fire, conflict, wr_ready, rd_ptr, wr_ptr,   |
// |                  count, empty, full, ovf_err, unf_err                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module banked_fifo_ptr
  import banked_fifo_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned BANK_DEPTH = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic                                     flush,
  input  logic                                     we,
  input  logic                                     re,
  output logic                                     rd_fire,
  output logic                                     wr_fire,
  output logic                                     conflict,
  output logic                                     wr_ready,
  output logic [ptr_w(NUM_BANKS, BANK_DEPTH)-1:0]  rd_ptr,
  output logic [ptr_w(NUM_BANKS, BANK_DEPTH)-1:0]  wr_ptr,
  output logic [cnt_w(NUM_BANKS, BANK_DEPTH)-1:0]  count,
  output logic                                     empty,
  output logic                                     full,
  output logic                                     ovf_err,
  output logic                                     unf_err
);

  localparam int unsigned DEPTH = NUM_BANKS * BANK_DEPTH;
  localparam int unsigned BW    = bank_w(NUM_BANKS);
  localparam int unsigned PW    = ptr_w(NUM_BANKS, BANK_DEPTH);
  localparam int unsigned CW    = cnt_w(NUM_BANKS, BANK_DEPTH);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_err_q, ovf_err_d;
  logic          unf_err_q, unf_err_d;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign rd_fire  = en && re && !empty && !flush;
  assign conflict = rd_fire &&
                    (bank_of(32'(rd_ptr_q), BW) == bank_of(32'(wr_ptr_q), BW));
  // rst is in this term so that no write can fire while reset is held.
  assign wr_ready = rst && en && !flush && !full && !conflict;
  assign wr_fire  = we && wr_ready;

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    ovf_err_d = ovf_err_q;
    unf_err_d = unf_err_q;
    if (flush) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      ovf_err_d = 1'b0;
      unf_err_d = 1'b0;
    end else begin
      if (rd_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      if (wr_fire) wr_ptr_d = wr_ptr_q + PW'(1);
      case ({wr_fire, rd_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      // A stall caused only by a conflict is normal backpressure, so it is
      // not flagged. Only a write attempted against a full FIFO is an error.
      if (we && en && full) ovf_err_d = 1'b1;
      if (re && en && empty) unf_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      ovf_err_q <= 1'b0;
      unf_err_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
      unf_err_q <= unf_err_d;
    end
  end

  assign rd_ptr  = rd_ptr_q;
  assign wr_ptr  = wr_ptr_q;
  assign count   = count_q;
  assign ovf_err = ovf_err_q;
  assign unf_err = unf_err_q;

endmodule
`default_nettype wire

// File: rtl/banked_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : banked_fifo_ctrl                                           |
// | Description : FIFO controller built from NUM_BANKS single-port SRAM      |
// |               banks with 1-cycle read latency. Consecutive entries are   |
// |               interleaved across the banks.                              |
// | Ports       : write side  - we, wr_data, wr_ready                        |
// |               read side   - re, rd_data, rd_valid                        |
// |               status      - empty, full, almost_full, count,             |
// |                             ovf_err, unf_err                             |
// |               RAM side    - ram_en, ram_we, ram_addr, ram_wdata,         |
// |                             ram_rdata (lane b = bank b)                  |
// |               control     - clk, rst (async, active low), en, flush      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module banked_fifo_ctrl
  import banked_fifo_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned BANK_DEPTH = 16,
  parameter int unsigned AF_THRESH  = 12
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en,
  input  logic                                         flush,
  input  logic                                         we,
  input  logic [DATA_W-1:0]                            wr_data,
  output logic                                         wr_ready,
  input  logic                                         re,
  output logic [DATA_W-1:0]                            rd_data,
  output logic                                         rd_valid,
  output logic                                         empty,
  output logic                                         full,
  output logic                                         almost_full,
  output logic [cnt_w(NUM_BANKS, BANK_DEPTH)-1:0]      count,
  output logic                                         ovf_err,
  output logic                                         unf_err,
  output logic [NUM_BANKS-1:0]                         ram_en,
  output logic [NUM_BANKS-1:0]                         ram_we,
  output logic [NUM_BANKS*row_w(BANK_DEPTH)-1:0]       ram_addr,
  output logic [NUM_BANKS*DATA_W-1:0]                  ram_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]                  ram_rdata
);

  localparam int unsigned BW  = bank_w(NUM_BANKS);
  localparam int unsigned RAW = row_w(BANK_DEPTH);
  localparam int unsigned PW  = ptr_w(NUM_BANKS, BANK_DEPTH);
  localparam int unsigned CW  = cnt_w(NUM_BANKS, BANK_DEPTH);

  logic          rd_fire, wr_fire, conflict;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [BW-1:0] rd_bank, wr_bank;
  logic [RAW-1:0] rd_row, wr_row;
  logic [DATA_W-1:0] rdata_lane [NUM_BANKS];

  logic          rd_valid_q, rd_valid_d;
  logic [BW-1:0] rd_bank_q, rd_bank_d;

  banked_fifo_ptr #(
    .NUM_BANKS  (NUM_BANKS),
    .BANK_DEPTH (BANK_DEPTH)
  ) u_ptr (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .flush    (flush),
    .we       (we),
    .re       (re),
    .rd_fire  (rd_fire),
    .wr_fire  (wr_fire),
    .conflict (conflict),
    .wr_ready (wr_ready),
    .rd_ptr   (rd_ptr),
    .wr_ptr   (wr_ptr),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .ovf_err  (ovf_err),
    .unf_err  (unf_err)
  );

  assign rd_bank = BW'(bank_of(32'(rd_ptr), BW));
  assign wr_bank = BW'(bank_of(32'(wr_ptr), BW));
  assign rd_row  = RAW'(row_of(32'(rd_ptr), BW, RAW));
  assign wr_row  = RAW'(row_of(32'(wr_ptr), BW, RAW));

  assign almost_full = (count >= CW'(AF_THRESH));

  // Per-bank routing. The arbiter never lets a read and a write hit the same
  // bank, so at most one of rd_hit and wr_hit is set in any lane.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic rd_hit, wr_hit;
    assign rd_hit        = rd_fire && (rd_bank == BW'(b));
    assign wr_hit        = wr_fire && (wr_bank == BW'(b));
    assign ram_en[b]     = rd_hit || wr_hit;
    assign ram_we[b]     = wr_hit;
    assign ram_addr[b*RAW +: RAW]       = rd_hit ? rd_row : (wr_hit ? wr_row : '0);
    assign ram_wdata[b*DATA_W +: DATA_W] = wr_hit ? wr_data : '0;
    assign rdata_lane[b] = ram_rdata[b*DATA_W +: DATA_W];
  end

  // The bank select is captured only when a read fires. This keeps rd_data
  // stable between reads.
  always_comb begin
    rd_valid_d = rd_fire;
    rd_bank_d  = rd_fire ? rd_bank : rd_bank_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_bank_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_bank_q  <= rd_bank_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rdata_lane[rd_bank_q];

endmodule
`default_nettype wire

// File: tb/tb_banked_fifo_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_banked_fifo_ctrl                                        |
// | Description : Bench for banked_fifo_ctrl with NUM_BANKS=2, BANK_DEPTH=4, |
// |               AF_THRESH=6, DATA_W=8. The reference is an entry queue     |
// |               plus running read/write totals. Bank and row come from     |
// |               total modulo arithmetic.                                   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_banked_fifo_ctrl;

  localparam int DATA_W     = 8;
  localparam int NUM_BANKS  = 2;
  localparam int BANK_DEPTH = 4;
  localparam int AF_THRESH  = 6;
  localparam int DEPTH      = NUM_BANKS * BANK_DEPTH;
  localparam int RAW        = 2;
  localparam int CW         = 4;

  logic clk, rst, en, flush, we, re;
  logic [DATA_W-1:0] wr_data, rd_data;
  logic wr_ready, rd_valid, empty, full, almost_full, ovf_err, unf_err;
  logic [CW-1:0] count;
  logic [NUM_BANKS-1:0] ram_en, ram_we;
  logic [NUM_BANKS*RAW-1:0] ram_addr;
  logic [NUM_BANKS*DATA_W-1:0] ram_wdata, ram_rdata;

  banked_fifo_ctrl #(
    .DATA_W(DATA_W), .NUM_BANKS(NUM_BANKS), .BANK_DEPTH(BANK_DEPTH), .AF_THRESH(AF_THRESH)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .we(we), .wr_data(wr_data),
    .wr_ready(wr_ready), .re(re), .rd_data(rd_data), .rd_valid(rd_valid),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count),
    .ovf_err(ovf_err), .unf_err(unf_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port SRAM macros with 1-cycle read latency.
  logic [DATA_W-1:0] mem [NUM_BANKS][BANK_DEPTH];
  initial ram_rdata = '0;
  always @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (ram_en[b]) begin
        if (ram_we[b]) mem[b][ram_addr[b*RAW +: RAW]] <= ram_wdata[b*DATA_W +: DATA_W];
        else           ram_rdata[b*DATA_W +: DATA_W] <= mem[b][ram_addr[b*RAW +: RAW]];
      end
    end
  end

  // Reference model state.
  logic [DATA_W-1:0] q[$];
  int unsigned rd_cnt, wr_cnt;
  bit m_ovf, m_unf, m_vld;
  logic [DATA_W-1:0] m_rdata;
  int checks, errors;
  string phase;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    rd_cnt = 0; wr_cnt = 0;
    m_ovf = 0; m_unf = 0; m_vld = 0;
  endtask

  // Drive one cycle of inputs just after a falling edge. Check every output
  // against the model before the rising edge, then advance the model.
  task automatic step(input bit i_we, input logic [DATA_W-1:0] wd, input bit i_re,
                      input bit i_fl, input bit i_en);
    bit e_empty, e_rdf, e_conf, e_wrr, e_wrf;
    int rb, wb;
    logic [NUM_BANKS-1:0] e_ren, e_rwe;
    logic [NUM_BANKS*RAW-1:0] e_addr;
    logic [NUM_BANKS*DATA_W-1:0] e_wd;
    we = i_we; wr_data = wd; re = i_re; flush = i_fl; en = i_en;
    #1;
    e_empty = (q.size() == 0);
    rb = int'(rd_cnt % NUM_BANKS);
    wb = int'(wr_cnt % NUM_BANKS);
    e_rdf  = i_en && i_re && !e_empty && !i_fl;
    e_conf = e_rdf && (rb == wb);
    e_wrr  = i_en && !i_fl && (q.size() < DEPTH) && !e_conf;
    e_wrf  = i_we && e_wrr;
    e_ren = '0; e_rwe = '0; e_addr = '0; e_wd = '0;
    if (e_rdf) begin
      e_ren[rb] = 1'b1;
      e_addr[rb*RAW +: RAW] = RAW'((rd_cnt / NUM_BANKS) % BANK_DEPTH);
    end
    if (e_wrf) begin
      e_ren[wb] = 1'b1;
      e_rwe[wb] = 1'b1;
      e_addr[wb*RAW +: RAW] = RAW'((wr_cnt / NUM_BANKS) % BANK_DEPTH);
      e_wd[wb*DATA_W +: DATA_W] = wd;
    end
    check("wr_ready", 64'(wr_ready), 64'(e_wrr));
    check("ram_en", 64'(ram_en), 64'(e_ren));
    check("ram_we", 64'(ram_we), 64'(e_rwe));
    check("ram_addr", 64'(ram_addr), 64'(e_addr));
    check("ram_wdata", 64'(ram_wdata), 64'(e_wd));
    check("count", 64'(count), 64'(q.size()));
    check("empty", 64'(empty), 64'(e_empty));
    check("full", 64'(full), 64'(q.size() == DEPTH));
    check("almost_full", 64'(almost_full), 64'(q.size() >= AF_THRESH));
    check("ovf_err", 64'(ovf_err), 64'(m_ovf));
    check("unf_err", 64'(unf_err), 64'(m_unf));
    check("rd_valid", 64'(rd_valid), 64'(m_vld));
    if (m_vld) check("rd_data", 64'(rd_data), 64'(m_rdata));
    @(posedge clk);
    m_vld = e_rdf;
    if (i_fl) begin
      model_reset();
    end else begin
      if (i_we && i_en && q.size() == DEPTH) m_ovf = 1;
      if (i_re && i_en && e_empty) m_unf = 1;
      if (e_rdf) begin m_rdata = q.pop_front(); rd_cnt++; end
      if (e_wrf) begin q.push_back(wd); wr_cnt++; end
    end
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; en = 1'b0; flush = 1'b0; we = 1'b0; re = 1'b0; wr_data = '0;
    model_reset();

    phase = "reset";
    #2;
    check("count", 64'(count), 64'd0);
    check("empty", 64'(empty), 64'd1);
    check("full", 64'(full), 64'd0);
    check("rd_valid", 64'(rd_valid), 64'd0);
    check("ram_en", 64'(ram_en), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    phase = "fill";
    for (int i = 0; i < DEPTH; i++) step(1, DATA_W'(8'h10 + i), 0, 0, 1);
    check("full_after8", 64'(full), 64'd1);
    step(1, 8'h18, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("ovf_set", 64'(ovf_err), 64'd1);

    phase = "drain";
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, 1);
    check("empty_after8", 64'(empty), 64'd1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    check("unf_set", 64'(unf_err), 64'd1);

    phase = "conflict";
    step(0, 0, 0, 1, 1);
    step(1, 8'hA0, 0, 0, 1);
    step(1, 8'hA1, 0, 0, 1);
    step(1, 8'hA2, 1, 0, 1);
    step(1, 8'hA3, 1, 0, 1);
    step(0, 0, 0, 0, 1);
    check("count_1", 64'(count), 64'd1);
    check("no_ovf", 64'(ovf_err), 64'd0);

    phase = "wrap";
    step(1, 8'hB0, 0, 0, 1);
    step(1, 8'hB1, 0, 0, 1);
    for (int i = 0; i < 40; i++) step(1, DATA_W'($urandom), 1, 0, 1);
    step(0, 0, 0, 0, 1);
    check("count_3", 64'(count), 64'd3);

    phase = "flush";
    for (int i = 0; i < 2 * DEPTH && q.size() < DEPTH; i++) step(1, DATA_W'($urandom), 0, 0, 1);
    step(1, 8'hEE, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1);
    step(1, 8'hEF, 1, 1, 1);
    step(0, 0, 0, 0, 1);
    check("count_0", 64'(count), 64'd0);
    check("ovf_clr", 64'(ovf_err), 64'd0);

    phase = "random";
    for (int i = 0; i < 120; i++)
      step(1'($urandom), DATA_W'($urandom), 1'($urandom),
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) != 0));

    phase = "async_reset";
    for (int i = 0; i < 3; i++) step(1, DATA_W'($urandom), 0, 0, 1);
    step(1, DATA_W'($urandom), 1, 0, 1);
    we = 1'b1; re = 1'b1; en = 1'b1; flush = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("count", 64'(count), 64'd0);
    check("empty", 64'(empty), 64'd1);
    check("almost_full", 64'(almost_full), 64'd0);
    check("rd_valid", 64'(rd_valid), 64'd0);
    check("wr_ready", 64'(wr_ready), 64'd0);
    check("ram_en", 64'(ram_en), 64'd0);
    check("ram_addr", 64'(ram_addr), 64'd0);
    check("ram_wdata", 64'(ram_wdata), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    step(0, 0, 0, 0, 1);
    step(1, 8'h5A, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
